// File: rtl/irq_pri_pkg.sv
// Shared definitions for the interrupt priority controller: state encoding,
// default request count and a constant-evaluable ceil(log2) helper.
package irq_pri_pkg;

   localparam int DEFAULT_N = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            result = i + 1;
         end else begin
            result = result;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/pri_rotate_enc.sv
// Combinational rotating priority encoder: searches downward from start_i,
// wrapping from 0 to N-1. Fixed-priority builds pin the start to N-1.
module pri_rotate_enc
   import irq_pri_pkg::*;
#(
   parameter int N           = DEFAULT_N,
   parameter int W           = clog2(N),
   parameter bit ROUND_ROBIN = 1'b0
) (
   input  logic [N-1:0] vec_i,
   input  logic [W-1:0] start_i,
   output logic [W-1:0] idx_o,
   output logic         any_o
);

   logic [W-1:0] start_s;

   assign start_s = ROUND_ROBIN ? start_i : W'(N - 1);

   // Indices above start rank below every index at or below start, so the
   // second pass overrides the first; within each pass the highest hit wins.
   always_comb begin
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (vec_i[i] && (i > int'(start_s))) begin
            idx_o = W'(i);
            any_o = 1'b1;
         end else begin
            idx_o = idx_o;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (vec_i[i] && (i <= int'(start_s))) begin
            idx_o = W'(i);
            any_o = 1'b1;
         end else begin
            idx_o = idx_o;
         end
      end
   end

endmodule

// File: rtl/irq_priority_ctrl.sv
// Registered interrupt priority controller with pending latch, fixed or
// round-robin arbitration, valid/ack handshake and EI/EO/GS cascade.
module irq_priority_ctrl
   import irq_pri_pkg::*;
#(
   parameter int N           = DEFAULT_N,
   parameter int W           = clog2(N),
   parameter bit ROUND_ROBIN = 1'b0,
   parameter bit EDGE_MODE   = 1'b0
) (
   input  logic         iClk,
   input  logic         iRst,
   input  logic         iEI,
   input  logic [N-1:0] iData,
   input  logic [N-1:0] iMask,
   input  logic         iAck,
   output logic [W-1:0] oData,
   output logic         oValid,
   output logic         oGS,
   output logic         oEO,
   output logic [N-1:0] oPend
);

   state_e       state_q, state_d;
   logic [N-1:0] data_q;
   logic [N-1:0] pend_q, pend_d;
   logic [W-1:0] ptr_q, ptr_d;
   logic [W-1:0] idx_q, idx_d;
   logic         valid_q, valid_d;
   logic         gs_q, gs_d;
   logic         eo_q, eo_d;

   logic [N-1:0] set_s;
   logic [N-1:0] clr_s;
   logic [N-1:0] elig_s;
   logic [W-1:0] win_idx_s;
   logic         win_any_s;

   assign set_s  = EDGE_MODE ? (data_q & ~iData) : ~data_q;
   assign clr_s  = ((state_q == GRANT) && iAck) ? ({{(N-1){1'b0}}, 1'b1} << idx_q) : '0;
   assign elig_s = pend_q & ~iMask;

   pri_rotate_enc #(
      .N           (N),
      .W           (W),
      .ROUND_ROBIN (ROUND_ROBIN)
   ) u_enc (
      .vec_i   (elig_s),
      .start_i (ptr_q),
      .idx_o   (win_idx_s),
      .any_o   (win_any_s)
   );

   // Set is OR-ed after clear so a coincident new event survives the ack.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      ptr_d   = ptr_q;
      pend_d  = (pend_q & ~clr_s) | set_s;
      case (state_q)
         IDLE: begin
            if (!iEI && win_any_s) begin
               state_d = GRANT;
               idx_d   = win_idx_s;
               valid_d = 1'b1;
            end else begin
               valid_d = 1'b0;
            end
         end
         GRANT: begin
            if (iAck) begin
               state_d = IDLE;
               valid_d = 1'b0;
               if (ROUND_ROBIN) begin
                  ptr_d = (idx_q == '0) ? W'(N - 1) : (idx_q - W'(1));
               end else begin
                  ptr_d = ptr_q;
               end
            end else if (iEI) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end else begin
               valid_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase
      gs_d = ~valid_d;
      eo_d = iEI | valid_d | (|(pend_d & ~iMask));
   end

   // State, pending and output registers.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state_q <= IDLE;
         data_q  <= '1;
         pend_q  <= '0;
         ptr_q   <= W'(N - 1);
         idx_q   <= '0;
         valid_q <= 1'b0;
         gs_q    <= 1'b1;
         eo_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         data_q  <= iData;
         pend_q  <= pend_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         gs_q    <= gs_d;
         eo_q    <= eo_d;
      end
   end

   assign oData  = idx_q;
   assign oValid = valid_q;
   assign oGS    = gs_q;
   assign oEO    = eo_q;
   assign oPend  = pend_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Self-checking bench: three controller variants (edge/fixed, level/round-robin,
// level/fixed) driven by directed scenarios and random stimulus against a model.
module tb_irq_priority_ctrl;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         ei  = 1'b0;
   logic [N-1:0] data = 8'hFF;
   logic [N-1:0] mask = 8'h00;
   logic [2:0]   ack  = 3'b000;

   logic [W-1:0] od    [3];
   logic         ov    [3];
   logic         ogs   [3];
   logic         oeo   [3];
   logic [N-1:0] opend [3];

   int checks = 0;
   int errors = 0;

   // model state per instance: 0 = edge/fixed, 1 = level/rr, 2 = level/fixed
   int       edge_cfg [3] = '{1, 0, 0};
   int       rr_cfg   [3] = '{0, 1, 0};
   bit [7:0] m_prev [3];
   bit [7:0] m_pend [3];
   bit       m_gnt  [3];
   int       m_idx  [3];
   int       m_ptr  [3];
   bit       m_eo   [3];

   always #5 clk = ~clk;

   irq_priority_ctrl #(.N(N), .ROUND_ROBIN(1'b0), .EDGE_MODE(1'b1)) u_edge (
      .iClk(clk), .iRst(rst), .iEI(ei), .iData(data), .iMask(mask), .iAck(ack[0]),
      .oData(od[0]), .oValid(ov[0]), .oGS(ogs[0]), .oEO(oeo[0]), .oPend(opend[0]));

   irq_priority_ctrl #(.N(N), .ROUND_ROBIN(1'b1), .EDGE_MODE(1'b0)) u_lvl_rr (
      .iClk(clk), .iRst(rst), .iEI(ei), .iData(data), .iMask(mask), .iAck(ack[1]),
      .oData(od[1]), .oValid(ov[1]), .oGS(ogs[1]), .oEO(oeo[1]), .oPend(opend[1]));

   irq_priority_ctrl #(.N(N), .ROUND_ROBIN(1'b0), .EDGE_MODE(1'b0)) u_lvl_fix (
      .iClk(clk), .iRst(rst), .iEI(ei), .iData(data), .iMask(mask), .iAck(ack[2]),
      .oData(od[2]), .oValid(ov[2]), .oGS(ogs[2]), .oEO(oeo[2]), .oPend(opend[2]));

   // reference model: pending set of request numbers, one grant at a time
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int d = 0; d < 3; d++) begin
            m_prev[d] = 8'hFF; m_pend[d] = 8'h00; m_gnt[d] = 1'b0;
            m_idx[d] = 0; m_ptr[d] = N - 1; m_eo[d] = 1'b1;
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            bit [7:0] setv, clr, elig, np;
            int win;
            setv = (edge_cfg[d] != 0) ? (m_prev[d] & ~data) : ~m_prev[d];
            clr  = 8'h00;
            elig = m_pend[d] & ~mask;
            if (m_gnt[d]) begin
               if (ack[d]) begin
                  clr[m_idx[d]] = 1'b1;
                  m_gnt[d] = 1'b0;
                  m_ptr[d] = (m_idx[d] == 0) ? N - 1 : m_idx[d] - 1;
               end else if (ei) begin
                  m_gnt[d] = 1'b0;
               end
            end else if (!ei && elig != 8'h00) begin
               win = -1;
               for (int k = 0; k < N; k++) begin
                  int j;
                  j = (rr_cfg[d] != 0) ? (m_ptr[d] - k + N) % N : N - 1 - k;
                  if (win < 0 && elig[j]) win = j;
               end
               m_gnt[d] = 1'b1;
               m_idx[d] = win;
            end
            np = (m_pend[d] & ~clr) | setv;
            m_pend[d] = np;
            m_eo[d]   = ei | m_gnt[d] | ((np & ~mask) != 8'h00);
            m_prev[d] = data;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; data = 8'hFF; mask = 8'h00; ei = 1'b0; ack = 3'b000;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (ov[d] !== 1'b0 || ogs[d] !== 1'b1 || oeo[d] !== 1'b1 || od[d] !== 3'd0 || opend[d] !== 8'h00) begin
            errors++;
            $display("FAIL reset[%0d]: got v=%b gs=%b eo=%b d=%0d p=%h expected v=0 gs=1 eo=1 d=0 p=00",
                     d, ov[d], ogs[d], oeo[d], od[d], opend[d]);
         end
      end
      do_reset();
   endtask

   task automatic test_edge_sequence();
      int seq [5] = '{7, 5, 3, 2, 0};
      do_reset();
      data = 8'b0101_0010;
      @(negedge clk);
      checks++;
      if (opend[0] !== 8'hAD || ov[0] !== 1'b0) begin
         errors++;
         $display("FAIL edge_latency1: got p=%h v=%b expected p=ad v=0", opend[0], ov[0]);
      end
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b1) begin
         errors++;
         $display("FAIL edge_latency2: got v=%b expected v=1", ov[0]);
      end
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 8 && ov[0] !== 1'b1; c++) @(negedge clk);
         checks++;
         if (ov[0] !== 1'b1 || od[0] !== W'(seq[g])) begin
            errors++;
            $display("FAIL edge_seq[%0d]: got v=%b d=%0d expected v=1 d=%0d", g, ov[0], od[0], seq[g]);
         end
         ack[0] = 1'b1;
         @(negedge clk);
         ack[0] = 1'b0;
      end
      checks++;
      if (ov[0] !== 1'b0 || oeo[0] !== 1'b0) begin
         errors++;
         $display("FAIL edge_done: got v=%b eo=%b expected v=0 eo=0", ov[0], oeo[0]);
      end
   endtask

   task automatic test_round_robin();
      int rr_exp [4] = '{7, 0, 7, 0};
      do_reset();
      data = 8'b0111_1110;
      for (int g = 0; g < 4; g++) begin
         for (int c = 0; c < 8 && !(ov[1] === 1'b1 && ov[2] === 1'b1); c++) @(negedge clk);
         checks++;
         if (ov[1] !== 1'b1 || od[1] !== W'(rr_exp[g])) begin
            errors++;
            $display("FAIL rr_seq[%0d]: got v=%b d=%0d expected v=1 d=%0d", g, ov[1], od[1], rr_exp[g]);
         end
         checks++;
         if (ov[2] !== 1'b1 || od[2] !== 3'd7) begin
            errors++;
            $display("FAIL fixed_seq[%0d]: got v=%b d=%0d expected v=1 d=7", g, ov[2], od[2]);
         end
         ack[2:1] = 2'b11;
         @(negedge clk);
         ack[2:1] = 2'b00;
      end
   endtask

   task automatic test_enable();
      do_reset();
      ei = 1'b1; data = 8'h00;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (ov[d] !== 1'b0 || ogs[d] !== 1'b1 || oeo[d] !== 1'b1 || opend[d] !== 8'hFF) begin
            errors++;
            $display("FAIL ei_off[%0d]: got v=%b gs=%b eo=%b p=%h expected v=0 gs=1 eo=1 p=ff",
                     d, ov[d], ogs[d], oeo[d], opend[d]);
         end
      end
      ei = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (ov[d] !== 1'b1 || od[d] !== 3'd7 || ogs[d] !== 1'b0) begin
            errors++;
            $display("FAIL ei_on[%0d]: got v=%b d=%0d gs=%b expected v=1 d=7 gs=0", d, ov[d], od[d], ogs[d]);
         end
      end
   endtask

   task automatic test_idle_hold();
      bit [2:0] acked;
      do_reset();
      acked = 3'b000;
      data = 8'hDF;
      @(negedge clk);
      data = 8'hFF;
      for (int c = 0; c < 12; c++) begin
         for (int d = 0; d < 3; d++) begin
            if (acked[d]) ack[d] = 1'b0;
            else if (ov[d] === 1'b1) begin ack[d] = 1'b1; acked[d] = 1'b1; end
         end
         @(negedge clk);
      end
      ack = 3'b000;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checks++;
         if (ov[d] !== 1'b0 || ogs[d] !== 1'b1 || oeo[d] !== 1'b0 || od[d] !== 3'd5 || opend[d] !== 8'h00) begin
            errors++;
            $display("FAIL idle_hold[%0d]: got v=%b gs=%b eo=%b d=%0d p=%h expected v=0 gs=1 eo=0 d=5 p=00",
                     d, ov[d], ogs[d], oeo[d], od[d], opend[d]);
         end
      end
   endtask

   task automatic test_mask();
      do_reset();
      mask = 8'h80;
      data = 8'b0101_0010;
      for (int c = 0; c < 8 && ov[0] !== 1'b1; c++) @(negedge clk);
      checks++;
      if (ov[0] !== 1'b1 || od[0] !== 3'd5) begin
         errors++;
         $display("FAIL mask_first: got v=%b d=%0d expected v=1 d=5", ov[0], od[0]);
      end
      mask = 8'hFF;
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b1 || od[0] !== 3'd5) begin
         errors++;
         $display("FAIL mask_after_grant: got v=%b d=%0d expected v=1 d=5", ov[0], od[0]);
      end
      ack[0] = 1'b1;
      @(negedge clk);
      ack[0] = 1'b0;
      mask = 8'h00;
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b1 || od[0] !== 3'd7) begin
         errors++;
         $display("FAIL mask_release: got v=%b d=%0d expected v=1 d=7", ov[0], od[0]);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      data = 8'hDF;
      for (int c = 0; c < 8 && ov[0] !== 1'b1; c++) @(negedge clk);
      checks++;
      if (ov[0] !== 1'b1 || od[0] !== 3'd5) begin
         errors++;
         $display("FAIL mid_pre: got v=%b d=%0d expected v=1 d=5", ov[0], od[0]);
      end
      rst = 1'b1;
      data = 8'hFF;
      #1;
      checks++;
      if (ov[0] !== 1'b0 || ogs[0] !== 1'b1 || oeo[0] !== 1'b1 || od[0] !== 3'd0 || opend[0] !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset: got v=%b gs=%b eo=%b d=%0d p=%h expected v=0 gs=1 eo=1 d=0 p=00",
                  ov[0], ogs[0], oeo[0], od[0], opend[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (ov[0] !== 1'b0 || opend[0] !== 8'h00) begin
         errors++;
         $display("FAIL mid_no_grant: got v=%b p=%h expected v=0 p=00", ov[0], opend[0]);
      end
      data = 8'hDF;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ov[0] !== 1'b1 || od[0] !== 3'd5) begin
         errors++;
         $display("FAIL mid_new_edge: got v=%b d=%0d expected v=1 d=5", ov[0], od[0]);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (ov[d] !== m_gnt[d] || ogs[d] !== ~m_gnt[d] || oeo[d] !== m_eo[d] ||
                od[d] !== W'(m_idx[d]) || opend[d] !== m_pend[d]) begin
               errors++;
               $display("FAIL random[%0d] cyc %0d: got v=%b gs=%b eo=%b d=%0d p=%h expected v=%b gs=%b eo=%b d=%0d p=%h",
                        d, c, ov[d], ogs[d], oeo[d], od[d], opend[d],
                        m_gnt[d], ~m_gnt[d], m_eo[d], m_idx[d], m_pend[d]);
            end
         end
         data = 8'($urandom) | 8'($urandom);
         mask = 8'($urandom) & 8'($urandom);
         ei   = ($urandom_range(0, 7) == 0);
         for (int d = 0; d < 3; d++) begin
            ack[d] = m_gnt[d] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         end
         @(negedge clk);
      end
      ack = 3'b000;
   endtask

   initial begin
      test_reset();
      test_edge_sequence();
      test_round_robin();
      test_enable();
      test_idle_hold();
      test_mask();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
